bidir_bus_port: RTL and testbench

- Fabric-side sequencer for a WIDTH-bit half-duplex tristate data bus.
- Drives the data, enable and strobe inputs of a bank of per-bit bidirectional pad buffers, and samples the pads' returned values.
- Accepts single read/write requests from a PicoBlaze-side port adapter.
- Enforces drive, hold and bus-turnaround timing so fabric and external device never drive simultaneously.

---
 rtl/bidir_bus_pkg.sv | 23 ++
 rtl/bidir_bus_sync.sv | 20 ++
 rtl/bidir_bus_port.sv | 143 ++++++++++++++
 tb/tb_bidir_bus_port.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bidir_bus_pkg.sv
// Shared types and default parameters for the bidir_bus_port sequencer
// and its helpers.
package bidir_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    HOLD   = 3'd2,
    TURN   = 3'd3,
    SAMPLE = 3'd4
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_CYC = 1;
  localparam int DEF_TURN_CYC = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bidir_bus_sync.sv
// WIDTH-bit two-flop synchronizer for the returned pad values; used only
// when BIDIR_BUS_PORT_SYNC_EN is defined.
module bidir_bus_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: synchronizer flops carry no reset; their contents flush within two
  // cycles and a reset term would only add load on the metastable stage.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/bidir_bus_port.sv
// Half-duplex tristate bus sequencer: drive/hold/turnaround/sample timing
// around single requests. Define BIDIR_BUS_PORT_SYNC_EN to synchronize pad_o.
module bidir_bus_port
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] pad_i,
  output logic             pad_t,
  input  logic [WIDTH-1:0] pad_o,
  output logic             bus_stb
);

  if (TURN_CYC < 1) begin : g_bad_turn
    $error("bidir_bus_port: TURN_CYC must be at least 1");
  end

  logic [WIDTH-1:0] cap_data;

`ifdef BIDIR_BUS_PORT_SYNC_EN
  localparam int SAMPLE_CYC = 3;
  bidir_bus_sync #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .d   (pad_o),
    .q   (cap_data)
  );
`else
  localparam int SAMPLE_CYC = 1;
  assign cap_data = pad_o;
`endif

  // The counter also has to span the synchronized SAMPLE phase.
  localparam int CNT_MAX = max3(HOLD_CYC, TURN_CYC, SAMPLE_CYC - 1);
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD   = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             cap_en;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d = !req_write;
          if (req_write) begin
            wdata_d = req_wdata;
            state_d = DRIVE;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LD;
          end
        end
      end
      DRIVE: begin
        if (HOLD_CYC > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = TURN;
          cnt_d   = TURN_LD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rd_q) begin
          state_d = SAMPLE;
          cnt_d   = SAMPLE_LD;
        end else begin
          state_d = IDLE;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cap_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      pad_t     <= 1'b1;
      pad_i     <= '0;
      bus_stb   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      req_ready <= (state_d == IDLE);
      pad_t     <= !((state_d == DRIVE) || (state_d == HOLD));
      bus_stb   <= (state_d == DRIVE) || (state_d == SAMPLE);
      rsp_valid <= cap_en;
      if (state_d == DRIVE) pad_i <= wdata_d;
      if (cap_en) rsp_rdata <= cap_data;
    end
  end

endmodule

// File: tb/tb_bidir_bus_port.sv
// Directed self-checking bench for bidir_bus_port: default timing instance
// plus a HOLD_CYC=0 / TURN_CYC=1 instance.
module tb_bidir_bus_port;

  localparam int TURN_A = 2;
  localparam int TURN_B = 1;
`ifdef BIDIR_BUS_PORT_SYNC_EN
  localparam int RD_LAT_A = TURN_A + 4;
  localparam int RD_LAT_B = TURN_B + 4;
`else
  localparam int RD_LAT_A = TURN_A + 2;
  localparam int RD_LAT_B = TURN_B + 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dev_data = 8'h00;

  logic       a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [7:0] a_req_wdata = 8'h00;
  logic       a_req_ready, a_rsp_valid, a_pad_t, a_bus_stb;
  logic [7:0] a_rsp_rdata, a_pad_i, a_pad_o;

  logic       b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [7:0] b_req_wdata = 8'h00;
  logic       b_req_ready, b_rsp_valid, b_pad_t, b_bus_stb;
  logic [7:0] b_rsp_rdata, b_pad_i, b_pad_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Pad model: the device drives only while the fabric has released the bus.
  assign a_pad_o = a_pad_t ? dev_data : a_pad_i;
  assign b_pad_o = b_pad_t ? dev_data : b_pad_i;

  always #5 clk = ~clk;

  bidir_bus_port dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .pad_i(a_pad_i), .pad_t(a_pad_t), .pad_o(a_pad_o), .bus_stb(a_bus_stb)
  );

  bidir_bus_port #(.WIDTH(8), .HOLD_CYC(0), .TURN_CYC(TURN_B)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .pad_i(b_pad_i), .pad_t(b_pad_t), .pad_o(b_pad_o), .bus_stb(b_bus_stb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues a read on dut_a in the current cycle and returns in its rsp_valid cycle.
  task automatic read_a(input logic [7:0] val, input string tag);
    dev_data    = val;
    a_req_valid = 1'b1;
    a_req_write = 1'b0;
    tick();
    a_req_valid = 1'b0;
    for (int c = 1; c <= RD_LAT_A; c++) begin
      check({tag, "_padt"}, 32'(a_pad_t), 32'd1);
      check({tag, "_stb"},  32'(a_bus_stb), 32'(c > TURN_A && c < RD_LAT_A));
      check({tag, "_rsp"},  32'(a_rsp_valid), 32'(c == RD_LAT_A));
      if (c < RD_LAT_A) tick();
    end
    check({tag, "_rdata"}, 32'(a_rsp_rdata), 32'(val));
    check({tag, "_ready"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    int viol, rel, ready_cyc, rsp_cyc, pulses;
    logic stb_seen, read_sent, got;

    // Reset held three cycles, then ten idle cycles.
    repeat (3) tick();
    reset = 1'b0;
    check("rst_pad_i", 32'(a_pad_i), 32'h0);
    check("rst_rdata", 32'(a_rsp_rdata), 32'h0);
    for (int c = 0; c < 10; c++) begin
      check("idle_flags", 32'({a_pad_t, a_bus_stb, a_req_ready, a_rsp_valid}), 32'b1010);
      tick();
    end

    // Write 0xA5 on the default instance.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'hA5;
    tick();
    a_req_valid = 1'b0; a_req_wdata = 8'h00;
    check("wr_c1", 32'({a_pad_t, a_bus_stb, a_req_ready, a_pad_i}), 32'({3'b010, 8'hA5}));
    tick();
    check("wr_c2", 32'({a_pad_t, a_bus_stb, a_req_ready, a_pad_i}), 32'({3'b000, 8'hA5}));
    tick();
    check("wr_c3", 32'({a_pad_t, a_bus_stb, a_req_ready}), 32'b100);
    tick();
    check("wr_c4", 32'({a_pad_t, a_bus_stb, a_req_ready}), 32'b100);
    tick();
    check("wr_c5", 32'({a_pad_t, a_req_ready}), 32'b11);

    // Read returning 0x3C.
    read_a(8'h3C, "rd3c");
    tick();

    // Write 0x11 followed by the earliest possible read of 0x7E.
    dev_data = 8'h7E;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h11;
    tick();
    a_req_valid = 1'b0;
    viol = 0; rel = 0; ready_cyc = 0; rsp_cyc = 0;
    stb_seen = 1'b0; read_sent = 1'b0; got = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c >= 3 && !a_pad_t) viol++;
      if (c >= 3 && a_pad_t && !a_bus_stb && !stb_seen) rel++;
      if (c >= 3 && a_bus_stb) stb_seen = 1'b1;
      if (a_rsp_valid) begin
        got = 1'b1;
        rsp_cyc = c;
        break;
      end
      if (a_req_ready && !read_sent) begin
        a_req_valid = 1'b1; a_req_write = 1'b0;
        read_sent = 1'b1;
        ready_cyc = c;
      end
      tick();
      a_req_valid = 1'b0;
    end
    check("wr_rd_ready_cyc", 32'(ready_cyc), 32'd5);
    check("wr_rd_no_drive", 32'(viol), 32'd0);
    check("wr_rd_turnaround", 32'(rel >= TURN_A), 32'd1);
    check("wr_rd_got_rsp", 32'(got), 32'd1);
    check("wr_rd_rsp_cyc", 32'(rsp_cyc), 32'(5 + RD_LAT_A));
    check("wr_rd_rdata", 32'(a_rsp_rdata), 32'h7E);
    tick();

    // Reset while the read is in TURN.
    dev_data = 8'h99;
    a_req_valid = 1'b1; a_req_write = 1'b0;
    tick();
    a_req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_flags", 32'({a_pad_t, a_bus_stb, a_req_ready, a_rsp_valid}), 32'b1010);
    check("abort_rdata", 32'(a_rsp_rdata), 32'h0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (a_rsp_valid) pulses++;
      tick();
    end
    check("abort_no_rsp", 32'(pulses), 32'd0);
    read_a(8'h55, "rd55");

    // Write presented in the rsp_valid cycle is accepted immediately.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h22;
    tick();
    a_req_valid = 1'b0;
    check("b2b_wr", 32'({a_pad_t, a_bus_stb, a_pad_i}), 32'({2'b01, 8'h22}));
    repeat (6) tick();

    // HOLD_CYC=0, TURN_CYC=1 instance: write 0xFF then read 0x6B.
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_wdata = 8'hFF;
    tick();
    b_req_valid = 1'b0;
    check("h0_c1", 32'({b_pad_t, b_bus_stb, b_req_ready, b_pad_i}), 32'({3'b010, 8'hFF}));
    tick();
    check("h0_c2", 32'({b_pad_t, b_bus_stb, b_req_ready}), 32'b100);
    tick();
    check("h0_c3", 32'({b_pad_t, b_req_ready}), 32'b11);
    dev_data = 8'h6B;
    b_req_valid = 1'b1; b_req_write = 1'b0;
    tick();
    b_req_valid = 1'b0;
    rsp_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (b_rsp_valid) begin
        rsp_cyc = c;
        break;
      end
      tick();
    end
    check("h0_rd_lat", 32'(rsp_cyc), 32'(RD_LAT_B));
    check("h0_rd_rdata", 32'(b_rsp_rdata), 32'h6B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
